// File: rtl/board_mem_arbiter.sv
// Arbitrates the single-port 64x4 board memory between four requesters
// (control, validator, datapath, view) using a request/grant handshake.
// The owner encoding is the same as memory_manage.
module board_mem_arbiter #(
    parameter int unsigned VIEW_QUANTUM = 64,
    parameter int unsigned MEM_RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [23:0] addr_flat,
    input  logic [15:0] wdata_flat,
    input  logic [3:0]  we,
    output logic [3:0]  gnt,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [5:0]  mem_addr,
    output logic [3:0]  mem_wdata,
    output logic        mem_we,
    input  logic [3:0]  mem_rdata,
    output logic [3:0]  rdata,
    output logic [3:0]  rdata_valid,
    output logic        preempted
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = $clog2(VIEW_QUANTUM + 1);
    localparam int unsigned PIPE_D = MEM_RD_LAT + 1;
    localparam logic [1:0]  VIEW_ID = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_e;

    state_e              state_q;
    logic [3:0]          gnt_q;
    logic [1:0]          owner_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_we_q;
    logic                preempted_q;
    logic [CNT_W-1:0]    hold_q;
    logic [CNT_W-1:0]    hold_d;
    logic [3:0]          vpipe_q [PIPE_D];

    logic [1:0]          winner_c;
    logic [ADDR_W-1:0]   own_addr_c;
    logic [DATA_W-1:0]   own_wdata_c;
    logic                own_req_c;
    logic                own_we_c;
    logic                others_c;
    logic                quantum_c;
    logic                access_c;
    logic [3:0]          rd_push_c;

    // Fixed priority: datapath > validator > control > view
    always_comb begin
        winner_c = VIEW_ID;
        if (req[2])      winner_c = 2'd2;
        else if (req[1]) winner_c = 2'd1;
        else if (req[0]) winner_c = 2'd0;
    end

    // Select the current owner's address and write-data slices
    always_comb begin
        own_addr_c  = '0;
        own_wdata_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == 2'(i)) begin
                own_addr_c  = addr_flat[ADDR_W*i +: ADDR_W];
                own_wdata_c = wdata_flat[DATA_W*i +: DATA_W];
            end
        end
    end

    assign own_req_c = req[owner_q];
    assign own_we_c  = we[owner_q] & (owner_q != VIEW_ID);
    assign others_c  = |req[2:0];
    assign hold_d    = hold_q + CNT_W'(1);
    assign quantum_c = (owner_q == VIEW_ID) && others_c && (hold_d == CNT_W'(VIEW_QUANTUM));
    assign access_c  = (state_q == GRANT) && own_req_c;
    assign rd_push_c = (access_c && !own_we_c) ? (4'b0001 << owner_q) : 4'b0000;

    // Arbitration FSM with registered grant and memory-side signals
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            preempted_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            preempted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    mem_we_q <= 1'b0;
                    hold_q   <= '0;
                    if (req != 4'b0000) begin
                        gnt_q   <= 4'b0001 << winner_c;
                        owner_q <= winner_c;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (own_req_c) begin
                        mem_addr_q  <= own_addr_c;
                        mem_wdata_q <= own_wdata_c;
                        mem_we_q    <= own_we_c;
                        if (quantum_c) begin
                            gnt_q       <= '0;
                            preempted_q <= 1'b1;
                            hold_q      <= '0;
                            state_q     <= TURN;
                        end else if ((owner_q == VIEW_ID) && others_c) begin
                            hold_q <= hold_d;
                        end else begin
                            hold_q <= '0;
                        end
                    end else begin
                        gnt_q    <= '0;
                        mem_we_q <= 1'b0;
                        hold_q   <= '0;
                        state_q  <= TURN;
                    end
                end
                TURN: begin
                    gnt_q    <= '0;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    gnt_q    <= '0;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Read-tag pipeline aligning the valid strobe with mem_rdata
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < PIPE_D; i++) vpipe_q[i] <= '0;
        end else begin
            vpipe_q[0] <= rd_push_c;
            for (int unsigned i = 1; i < PIPE_D; i++) vpipe_q[i] <= vpipe_q[i-1];
        end
    end

    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign preempted   = preempted_q;
    assign rdata_valid = vpipe_q[PIPE_D-1];
    assign rdata       = mem_rdata;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: directed scenarios plus a
// randomized run checked against a grant/queue level reference model.
module tb_board_mem_arbiter;

    localparam int unsigned LAT = 1;
    localparam int unsigned Q   = 64;

    logic        clk;
    logic        resetn;
    logic [3:0]  req;
    logic [23:0] addr_flat;
    logic [15:0] wdata_flat;
    logic [3:0]  we;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [5:0]  mem_addr;
    logic [3:0]  mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_rdata;
    logic [3:0]  rdata;
    logic [3:0]  rdata_valid;
    logic        preempted;

    logic [5:0]  r_addr  [4];
    logic [3:0]  r_wdata [4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    int          holder;
    int          cool;
    int          streak;
    logic [1:0]  m_owner;
    logic [5:0]  m_addr;
    logic [3:0]  m_wdata;
    logic        m_we;
    logic        m_pre;
    logic [3:0]  rv_ring [8];
    logic [3:0]  rd_ring [8];
    logic [3:0]  exp_rv;
    logic [3:0]  exp_rd;
    logic [3:0]  shadow  [64];

    // board memory with one cycle read latency
    logic [3:0]  bmem [64];
    logic        bmem_ready = 1'b0;

    board_mem_arbiter #(.VIEW_QUANTUM(Q), .MEM_RD_LAT(LAT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .addr_flat   (addr_flat),
        .wdata_flat  (wdata_flat),
        .we          (we),
        .gnt         (gnt),
        .owner       (owner),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .preempted   (preempted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_flat[6*i +: 6]  = r_addr[i];
            wdata_flat[4*i +: 4] = r_wdata[i];
        end
    end

    always @(posedge clk) begin
        if (!bmem_ready) begin
            for (int i = 0; i < 64; i++) bmem[i] <= 4'(i * 5 + 3);
            bmem_ready <= 1'b1;
            mem_rdata  <= 4'd0;
        end else begin
            if (mem_we) bmem[mem_addr] <= mem_wdata;
            mem_rdata <= bmem[mem_addr];
        end
    end

    function automatic logic [3:0] onehot(input int i);
        return 4'(1 << i);
    endfunction

    // Advance the reference model by one clock using the inputs now driven
    task automatic model_step();
        int idx;
        m_pre = 1'b0;
        if (!resetn) begin
            holder = -1; cool = 0; streak = 0;
            m_owner = 2'd0; m_addr = 6'd0; m_wdata = 4'd0; m_we = 1'b0;
            for (int i = 0; i < 8; i++) begin rv_ring[i] = 4'd0; rd_ring[i] = 4'd0; end
        end else if (holder >= 0) begin
            if (req[holder]) begin
                m_addr  = r_addr[holder];
                m_wdata = r_wdata[holder];
                m_we    = we[holder] && (holder != 3);
                if (m_we) begin
                    shadow[m_addr] = m_wdata;
                end else begin
                    idx = (cyc + 1 + int'(LAT)) % 8;
                    rv_ring[idx] = rv_ring[idx] | onehot(holder);
                    rd_ring[idx] = shadow[m_addr];
                end
                if (holder == 3 && req[2:0] != 3'b000) begin
                    streak++;
                    if (streak == int'(Q)) begin
                        holder = -1; cool = 1; m_pre = 1'b1; streak = 0;
                    end
                end else begin
                    streak = 0;
                end
            end else begin
                holder = -1; cool = 1; m_we = 1'b0; streak = 0;
            end
        end else if (cool > 0) begin
            cool--;
            m_we = 1'b0;
        end else begin
            m_we = 1'b0;
            if (req != 4'd0) begin
                holder  = req[2] ? 2 : req[1] ? 1 : req[0] ? 0 : 3;
                m_owner = 2'(holder);
                streak  = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        exp_rv = rv_ring[cyc % 8];
        exp_rd = rd_ring[cyc % 8];
        rv_ring[cyc % 8] = 4'd0;
    endtask

    task automatic settle();
        req = 4'd0;
        we  = 4'd0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req = 4'd0; we = 4'd0;
        for (int i = 0; i < 4; i++) begin r_addr[i] = 6'd0; r_wdata[i] = 4'd0; end
        repeat (3) tick();
        n_tests++;
        if ({gnt, owner, busy, mem_addr, mem_wdata, mem_we, rdata_valid, preempted} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_vals got gnt=%b owner=%b busy=%b addr=%0d wd=%0d we=%b rv=%b pre=%b required all zero",
                     gnt, owner, busy, mem_addr, mem_wdata, mem_we, rdata_valid, preempted);
        end
        resetn = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req got gnt=%b busy=%b required 0000/0", gnt, busy);
        end
    endtask

    task automatic test_view_grant();
        req = 4'b1000; we = 4'b1000; r_addr[3] = 6'd12; r_wdata[3] = 4'd9;
        tick();
        n_tests++;
        if (gnt !== 4'b1000 || owner !== 2'b11 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL view_grant got gnt=%b owner=%b busy=%b required 1000/11/1", gnt, owner, busy);
        end
        tick();
        n_tests++;
        if (mem_we !== 1'b0 || mem_addr !== 6'd12) begin
            n_fail++;
            $display("FAIL view_readonly got we=%b addr=%0d required 0/12", mem_we, mem_addr);
        end
        settle();
        n_tests++;
        if (busy !== 1'b0 || owner !== 2'b11) begin
            n_fail++;
            $display("FAIL view_release got busy=%b owner=%b required 0/11", busy, owner);
        end
    endtask

    task automatic test_priority();
        int n;
        req = 4'b0111; we = 4'd0;
        tick();
        n_tests++;
        if (gnt !== 4'b0100 || owner !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_first got gnt=%b owner=%b required 0100/10", gnt, owner);
        end
        req = 4'b0011;
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_turn got gnt=%b busy=%b required 0000/1", gnt, busy);
        end
        n = 1;
        while (gnt !== 4'b0010 && n < 8) begin tick(); n++; end
        n_tests++;
        if (gnt !== 4'b0010 || n != 3) begin
            n_fail++;
            $display("FAIL prio_second got gnt=%b after %0d cycles required 0010 after 3", gnt, n);
        end
        req = 4'b0001;
        n = 0;
        while (gnt !== 4'b0001 && n < 8) begin tick(); n++; end
        n_tests++;
        if (gnt !== 4'b0001 || n != 3) begin
            n_fail++;
            $display("FAIL prio_third got gnt=%b after %0d cycles required 0001 after 3", gnt, n);
        end
        settle();
    endtask

    task automatic test_read_pipeline();
        logic [3:0] d9, d17;
        d9 = shadow[9]; d17 = shadow[17];
        req = 4'b0010; we = 4'd0; r_addr[1] = 6'd9;
        tick();
        tick();
        n_tests++;
        if (mem_addr !== 6'd9 || rdata_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_addr9 got addr=%0d rv=%b required 9/0000", mem_addr, rdata_valid);
        end
        r_addr[1] = 6'd17;
        tick();
        n_tests++;
        if (mem_addr !== 6'd17 || rdata_valid !== 4'b0010 || rdata !== d9) begin
            n_fail++;
            $display("FAIL rd_valid9 got addr=%0d rv=%b rdata=%0d required 17/0010/%0d", mem_addr, rdata_valid, rdata, d9);
        end
        req = 4'd0;
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || rdata_valid !== 4'b0010 || rdata !== d17) begin
            n_fail++;
            $display("FAIL rd_valid17_turn got gnt=%b rv=%b rdata=%0d required 0000/0010/%0d", gnt, rdata_valid, rdata, d17);
        end
        tick();
        n_tests++;
        if (rdata_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_drained got rv=%b required 0000", rdata_valid);
        end
        settle();
    endtask

    task automatic test_write();
        req = 4'b0100; we = 4'b0100; r_addr[2] = 6'd63; r_wdata[2] = 4'd6;
        tick();
        tick();
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd63 || mem_wdata !== 4'd6) begin
            n_fail++;
            $display("FAIL wr_signals got we=%b addr=%0d wd=%0d required 1/63/6", mem_we, mem_addr, mem_wdata);
        end
        req = 4'd0; we = 4'd0;
        tick();
        n_tests++;
        if (rdata_valid !== 4'b0000 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_no_strobe got rv=%b we=%b required 0000/0", rdata_valid, mem_we);
        end
        settle();
        req = 4'b0010; r_addr[1] = 6'd63;
        repeat (3) tick();
        n_tests++;
        if (rdata_valid !== 4'b0010 || rdata !== 4'd6) begin
            n_fail++;
            $display("FAIL wr_readback got rv=%b rdata=%0d required 0010/6", rdata_valid, rdata);
        end
        settle();
    endtask

    task automatic test_preempt();
        int n;
        req = 4'b1000; r_addr[3] = 6'd5; r_addr[0] = 6'd1;
        tick();
        req = 4'b1001;
        n = 0;
        while (gnt === 4'b1000 && n < 200) begin tick(); n++; end
        n_tests++;
        if (n != int'(Q) || preempted !== 1'b1 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL preempt_time got hold=%0d pre=%b gnt=%b required %0d/1/0000", n, preempted, gnt, Q);
        end
        tick();
        n_tests++;
        if (preempted !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL preempt_pulse got pre=%b gnt=%b required 0/0000", preempted, gnt);
        end
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || owner !== 2'b00) begin
            n_fail++;
            $display("FAIL preempt_next got gnt=%b owner=%b required 0001/00", gnt, owner);
        end
        settle();
    endtask

    task automatic test_no_preempt();
        int ok;
        req = 4'b1000;
        tick();
        ok = 0;
        repeat (200) begin
            tick();
            if (gnt === 4'b1000 && preempted === 1'b0) ok++;
        end
        n_tests++;
        if (ok != 200) begin
            n_fail++;
            $display("FAIL view_alone got %0d held cycles required 200", ok);
        end
        settle();
    endtask

    task automatic test_random();
        logic [22:0] got, expv;
        logic [3:0]  eg;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                r_addr[i]  = 6'($urandom);
                r_wdata[i] = 4'($urandom);
            end
            we     = 4'($urandom);
            resetn = ($urandom_range(599) != 0);
            tick();
            eg   = (holder >= 0) ? onehot(holder) : 4'd0;
            got  = {gnt, owner, busy, mem_addr, mem_wdata, mem_we, rdata_valid, preempted};
            expv = {eg, m_owner, (holder >= 0 || cool > 0), m_addr, m_wdata, m_we, exp_rv, m_pre};
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL rand_outputs cyc=%0d got=%h required=%h", cyc, got, expv);
            end
            if (exp_rv != 4'd0) begin
                n_tests++;
                if (rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rand_rdata cyc=%0d got=%0d required=%0d", cyc, rdata, exp_rd);
                end
            end
        end
        resetn = 1'b1;
        settle();
    endtask

    task automatic test_reset_inflight();
        req = 4'b0100; we = 4'd0; r_addr[2] = 6'd20;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        n_tests++;
        if ({gnt, owner, busy, mem_addr, mem_wdata, mem_we, rdata_valid, preempted} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_inflight got gnt=%b owner=%b busy=%b addr=%0d we=%b rv=%b required all zero",
                     gnt, owner, busy, mem_addr, mem_we, rdata_valid);
        end
        resetn = 1'b1; req = 4'd0;
        tick();
        n_tests++;
        if (rdata_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_drop got rv=%b required 0000", rdata_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = 4'(i * 5 + 3);
        for (int i = 0; i < 8; i++) begin rv_ring[i] = 4'd0; rd_ring[i] = 4'd0; end
        holder = -1; cool = 0; streak = 0;
        m_owner = 2'd0; m_addr = 6'd0; m_wdata = 4'd0; m_we = 1'b0; m_pre = 1'b0;
        exp_rv = 4'd0; exp_rd = 4'd0;
        resetn = 1'b0; req = 4'd0; we = 4'd0;

        test_reset();
        test_view_grant();
        test_priority();
        test_read_pipeline();
        test_write();
        test_preempt();
        test_no_preempt();
        test_random();
        test_reset_inflight();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
Owns the single-port 64x4 board memory (8x8 squares, 4-bit piece code) and shares it between four requesters: control, move validator, datapath and view renderer. It replaces the hard-wired memory_manage mux with a request/grant handshake and registered memory-side signals. Its owner encoding matches memory_manage (00 control, 01 validator, 10 datapath, 11 view), so existing consumers can keep decoding owner. It also delivers per-requester read-data-valid strobes and preempts long view ownership.

Parameters:
VIEW_QUANTUM, 64, max consecutive cycles view may hold the grant while any other request is pending
MEM_RD_LAT, 1, memory read latency in cycles from mem_addr registered to mem_rdata valid (1 or 2)

Ports:
clk  in  1  system clock
resetn  in  1  reset; synchronous, active-low
req  in  4  request per requester, index 0 control, 1 validator, 2 datapath, 3 view
addr_flat  in  24  6-bit address per requester, requester i at [6i+5:6i]
wdata_flat  in  16  4-bit write data per requester, requester i at [4i+3:4i]
we  in  4  write enable per requester
gnt  out  4  one-hot grant, registered
owner  out  2  index of current/last owner, memory_manage encoding
busy  out  1  high in any state other than IDLE
mem_addr  out  6  registered address to board memory
mem_wdata  out  4  registered write data
mem_we  out  1  registered write enable
mem_rdata  in  4  read data from board memory
rdata  out  4  mem_rdata passed through unregistered
rdata_valid  out  4  one-hot pulse: rdata belongs to a read by requester i
preempted  out  1  one-cycle pulse when view's grant is revoked

Behaviour:
- Reset (resetn low at posedge): state IDLE; gnt=0, owner=00, busy=0, mem_addr=0, mem_wdata=0, mem_we=0, rdata_valid=0, preempted=0, hold counter=0, read pipeline flushed. Reads in flight are dropped, with no valid strobe.
- States: IDLE, GRANT, TURN.
- IDLE: if req != 0, choose a winner by fixed priority datapath(2) > validator(1) > control(0) > view(3). Set gnt[winner] and owner=winner on the next edge and go to GRANT. The first gnt is seen 1 cycle after req. With req=0, stay in IDLE.
- GRANT, each cycle with req[owner]=1:
  - Register mem_addr and mem_wdata from the owner's slices.
  - mem_we <= we[owner], except the view is read-only: mem_we forced to 0 when owner=11.
  - Every non-write cycle is a read. Push the owner tag into a MEM_RD_LAT+1 deep valid pipeline, so rdata_valid[owner] is asserted exactly MEM_RD_LAT+1 cycles after the cycle the address was presented with gnt high.
- Release: when req[owner]=0 in GRANT, clear gnt and mem_we on the next edge, then go to TURN. owner holds its value.
- TURN: lasts exactly 1 cycle, with mem_we=0 and gnt=0. The read pipeline keeps draining, so strobes go to the previous owner. Then go to IDLE; new requests are arbitrated in IDLE, never in TURN.
- Preemption:
  - The hold counter counts GRANT cycles while owner=11 and (req & 4'b0111) != 0. It resets on every entry to GRANT and whenever no other request is pending.
  - When the counter reaches VIEW_QUANTUM: clear gnt, pulse preempted for 1 cycle, go to TURN. View's req may stay high; view re-competes at lowest priority.
  - Non-view owners are never preempted.
- Simultaneous events:
  - Release and a new req in the same cycle: TURN first; the new winner is granted 2 cycles later.
  - Release on the exact quantum cycle: treated as a release, preempted stays 0.
- A requester must hold addr/wdata/we stable only while gnt is high; inputs of non-owners are ignored.
- A request that drops while in IDLE before being granted is simply never granted; there is no latching.

Test Plan:
- Reset with all req=0, then req[3]=1 -> gnt=4'b1000 one cycle later, owner=11, busy=1; mem_we stays 0 even with we[3]=1.
- req=4'b0111 together from IDLE -> gnt=4'b0100 (datapath). Release 2 -> TURN -> gnt=4'b0010. Release 1 -> gnt=4'b0001.
- Validator granted, reads addr 6'd9 then 6'd17 with MEM_RD_LAT=1 -> mem_addr shows 9 then 17; rdata_valid=4'b0010 on cycles +2 and +3 relative to each presentation; strobes still arrive after release during TURN.
- Datapath writes wdata=4'd6 to addr 6'd63 -> mem_we=1, mem_addr=63, mem_wdata=6 one cycle after presentation; no rdata_valid for the write.
- View holds the grant, control asserts req[0] -> after 64 cycles gnt drops, preempted pulses once, TURN, then gnt=4'b0001. With no competing req, view holds 200 cycles unpreempted.
- resetn low for 1 cycle while the datapath is granted with a read in flight -> all outputs return to reset values next cycle and no rdata_valid strobe appears.
